// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution unit: condition codes,
// NZCV bit positions and the set of supported flag-group splits.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // The 4 flag bits must split evenly into groups.
  function automatic bit is_legal_flag_groups(input int groups);
    return (groups == 1) || (groups == 2) || (groups == 4);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Purely combinational evaluation of an ARM condition field against NZCV.
module cond_eval
  import cond_pkg::*;
#(
  parameter bit UNCOND_AS_AL = 1'b1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = ge;
      COND_LT: condex = ~ge;
      COND_GT: condex = ~z & ge;
      COND_LE: condex = z | ~ge;
      COND_AL: condex = 1'b1;
      COND_NV: condex = UNCOND_AS_AL;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV register, condition gating of write enables,
// delayed per-group flag writes and a saturating fail counter.
// Optional flag save/restore shadow enabled by CONDLOGIC_FLAG_SAVE_EN.
module cond_unit
  import cond_pkg::*;
#(
  parameter int FLAG_GROUPS  = 2,
  parameter int FLAG_DELAY   = 1,
  parameter bit UNCOND_AS_AL = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Cond,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   NextPC,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   Issue,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   CondEx,
  output logic [3:0]             Flags,
  output logic [CNT_W-1:0]       CondFailCount
`ifdef CONDLOGIC_FLAG_SAVE_EN
  ,
  input  logic                   FlagSave,
  input  logic                   FlagRestore
`endif
);

  localparam int GW = 4 / FLAG_GROUPS;

  logic [3:0]             flags_reg;
  logic [FLAG_GROUPS-1:0] fw_pipe [0:FLAG_DELAY];
  logic [CNT_W-1:0]       cnt_reg;

  cond_eval #(.UNCOND_AS_AL(UNCOND_AS_AL)) u_eval (
    .cond   (Cond),
    .flags  (flags_reg),
    .condex (CondEx)
  );

  assign RegWrite      = RegW & CondEx;
  assign MemWrite      = MemW & CondEx;
  assign PCWrite       = NextPC | (PCS & CondEx);
  assign Flags         = flags_reg;
  assign CondFailCount = cnt_reg;

  assign fw_pipe[0] = FlagW & {FLAG_GROUPS{CondEx}};

  // Stage count of zero leaves fw_pipe[0] driving the group enables directly.
  generate
    for (genvar gi = 0; gi < FLAG_DELAY; gi++) begin : g_delay
      flopr #(.WIDTH(FLAG_GROUPS)) u_stage (
        .clk   (clk),
        .reset (reset),
        .d     (fw_pipe[gi]),
        .q     (fw_pipe[gi+1])
      );
    end
  endgenerate

`ifdef CONDLOGIC_FLAG_SAVE_EN
  logic [3:0] shadow_reg;

  // Shadow captures the pre-restore flags, so save+restore swaps cleanly.
  flopenr #(.WIDTH(4)) u_shadow (
    .clk   (clk),
    .reset (reset),
    .en    (FlagSave),
    .d     (flags_reg),
    .q     (shadow_reg)
  );
`endif

  generate
    for (genvar gi = 0; gi < FLAG_GROUPS; gi++) begin : g_group
      logic          grp_en;
      logic [GW-1:0] grp_d;
`ifdef CONDLOGIC_FLAG_SAVE_EN
      assign grp_en = fw_pipe[FLAG_DELAY][gi] | FlagRestore;
      assign grp_d  = FlagRestore ? shadow_reg[gi*GW +: GW] : ALUFlags[gi*GW +: GW];
`else
      assign grp_en = fw_pipe[FLAG_DELAY][gi];
      assign grp_d  = ALUFlags[gi*GW +: GW];
`endif
      flopenr #(.WIDTH(GW)) u_flags (
        .clk   (clk),
        .reset (reset),
        .en    (grp_en),
        .d     (grp_d),
        .q     (flags_reg[gi*GW +: GW])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      cnt_reg <= '0;
    else if (Issue && !CondEx && (cnt_reg != {CNT_W{1'b1}}))
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: a default instance (u0) and a
// FLAG_DELAY=2 / UNCOND_AS_AL=0 / CNT_W=4 instance (u1) share all inputs.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, Issue;
`ifdef CONDLOGIC_FLAG_SAVE_EN
  logic       FlagSave, FlagRestore;
`endif

  logic        pcw0, rw0, mw0, cx0;
  logic [3:0]  fl0;
  logic [15:0] cnt0;
  logic        pcw1, rw1, mw1, cx1;
  logic [3:0]  fl1;
  logic [3:0]  cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_unit u0 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Issue(Issue),
    .PCWrite(pcw0), .RegWrite(rw0), .MemWrite(mw0), .CondEx(cx0),
    .Flags(fl0), .CondFailCount(cnt0)
`ifdef CONDLOGIC_FLAG_SAVE_EN
    , .FlagSave(FlagSave), .FlagRestore(FlagRestore)
`endif
  );

  cond_unit #(.FLAG_GROUPS(2), .FLAG_DELAY(2), .UNCOND_AS_AL(1'b0), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Issue(Issue),
    .PCWrite(pcw1), .RegWrite(rw1), .MemWrite(mw1), .CondEx(cx1),
    .Flags(fl1), .CondFailCount(cnt1)
`ifdef CONDLOGIC_FLAG_SAVE_EN
    , .FlagSave(1'b0), .FlagRestore(1'b0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; Issue = 1'b0;
`ifdef CONDLOGIC_FLAG_SAVE_EN
    FlagSave = 1'b0; FlagRestore = 1'b0;
`endif
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Table of condition outcomes, written from the architectural definitions.
  function automatic logic exp_condex(input logic [3:0] c, input logic [3:0] f, input bit nv_true);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return nv_true;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11; Issue = 1'b1; NextPC = 1'b1;
    tick(); tick();
    checks++; if (fl0 !== 4'h0) begin errors++; $display("FAIL reset_flags0 got=%h exp=0", fl0); end
    checks++; if (fl1 !== 4'h0) begin errors++; $display("FAIL reset_flags1 got=%h exp=0", fl1); end
    checks++; if (pcw0 !== 1'b1) begin errors++; $display("FAIL reset_pcwrite_nextpc got=%b exp=1", pcw0); end
    Cond = 4'h0;  // EQ fails on zero flags; reset must still block counting
    tick();
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
    NextPC = 1'b0; #1;
    checks++; if (pcw0 !== 1'b0) begin errors++; $display("FAIL reset_pcwrite_idle got=%b exp=0", pcw0); end
    idle();
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_flag_write();
    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b0100;
    tick();
    checks++; if (fl0 !== 4'h0) begin errors++; $display("FAIL fw_not_early got=%b exp=0000", fl0); end
    FlagW = 2'b00; ALUFlags = 4'b0101;
    tick();
    checks++; if (fl0 !== 4'b0100) begin errors++; $display("FAIL fw_delay1 got=%b exp=0100", fl0); end
    checks++; if (fl1 !== 4'b0000) begin errors++; $display("FAIL fw_delay2_early got=%b exp=0000", fl1); end
    tick();
    checks++; if (fl1 !== 4'b0100) begin errors++; $display("FAIL fw_delay2 got=%b exp=0100", fl1); end
    Cond = 4'h0; RegW = 1'b1; #1;
    checks++; if (rw0 !== 1'b1) begin errors++; $display("FAIL eq_regwrite got=%b exp=1", rw0); end
    RegW = 1'b0; Cond = 4'h1; #1;
    checks++; if (rw0 !== 1'b0) begin errors++; $display("FAIL ne_regwrite_idle got=%b exp=0", rw0); end
    idle();
    $display("test_flag_write done flags=%b", fl0);
  endtask

  task automatic test_cond_fail();
    Cond = 4'h1; FlagW = 2'b11; MemW = 1'b1; Issue = 1'b1; ALUFlags = 4'b1011; PCS = 1'b1; #1;
    checks++; if (mw0 !== 1'b0) begin errors++; $display("FAIL ne_memwrite got=%b exp=0", mw0); end
    checks++; if (pcw0 !== 1'b0) begin errors++; $display("FAIL ne_pcwrite got=%b exp=0", pcw0); end
    tick();
    Issue = 1'b0; FlagW = 2'b00;
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL fail_cnt0 got=%0d exp=1", cnt0); end
    checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL fail_cnt1 got=%0d exp=1", cnt1); end
    tick(); tick(); tick();
    checks++; if (fl0 !== 4'b0100) begin errors++; $display("FAIL fail_noflag0 got=%b exp=0100", fl0); end
    checks++; if (fl1 !== 4'b0100) begin errors++; $display("FAIL fail_noflag1 got=%b exp=0100", fl1); end
    Cond = 4'h0; #1;
    checks++; if (mw0 !== 1'b1) begin errors++; $display("FAIL eq_memwrite got=%b exp=1", mw0); end
    checks++; if (pcw0 !== 1'b1) begin errors++; $display("FAIL eq_pcwrite got=%b exp=1", pcw0); end
    idle();
    $display("test_cond_fail done cnt=%0d", cnt0);
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'(f);
      tick();
      FlagW = 2'b00;
      tick(); tick();
      checks++; if (fl0 !== 4'(f) || fl1 !== 4'(f)) begin
        errors++; $display("FAIL sweep_load got=%h/%h exp=%h", fl0, fl1, f[3:0]);
      end
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        checks++; if (cx0 !== exp_condex(4'(c), 4'(f), 1'b1)) begin
          errors++; $display("FAIL sweep_u0 cond=%h flags=%h got=%b exp=%b", c[3:0], f[3:0], cx0, exp_condex(4'(c), 4'(f), 1'b1));
        end
        checks++; if (cx1 !== exp_condex(4'(c), 4'(f), 1'b0)) begin
          errors++; $display("FAIL sweep_u1 cond=%h flags=%h got=%b exp=%b", c[3:0], f[3:0], cx1, exp_condex(4'(c), 4'(f), 1'b0));
        end
      end
      $display("sweep flags=%h done", f[3:0]);
    end
    idle();
  endtask

  task automatic test_saturate();
    pulse_reset();
    Cond = 4'h0; Issue = 1'b1;
    repeat (20) tick();
    Issue = 1'b0;
    checks++; if (cnt1 !== 4'hF) begin errors++; $display("FAIL sat_cnt1 got=%h exp=f", cnt1); end
    checks++; if (cnt0 !== 16'd20) begin errors++; $display("FAIL sat_cnt0 got=%0d exp=20", cnt0); end
    tick();
    checks++; if (cnt1 !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h exp=f", cnt1); end
    idle();
    $display("test_saturate done cnt1=%h", cnt1);
  endtask

  task automatic test_reset_pending();
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
    tick();
    FlagW = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (fl1 !== 4'h0) begin errors++; $display("FAIL pend_flags1 got=%h exp=0", fl1); end
    checks++; if (fl0 !== 4'h0) begin errors++; $display("FAIL pend_flags0 got=%h exp=0", fl0); end
    idle();
    $display("test_reset_pending done");
  endtask

  task automatic test_back_to_back();
    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1000;
    tick();
    FlagW = 2'b01; ALUFlags = 4'b1011;
    tick();
    checks++; if (fl0 !== 4'b1000) begin errors++; $display("FAIL b2b_first got=%b exp=1000", fl0); end
    Cond = 4'h2; FlagW = 2'b00; ALUFlags = 4'b0010; #1;
    checks++; if (cx0 !== 1'b0) begin errors++; $display("FAIL b2b_old_flags got=%b exp=0", cx0); end
    tick();
    checks++; if (fl0 !== 4'b1010) begin errors++; $display("FAIL b2b_second got=%b exp=1010", fl0); end
    checks++; if (cx0 !== 1'b1) begin errors++; $display("FAIL b2b_new_flags got=%b exp=1", cx0); end
    idle();
    $display("test_back_to_back done flags=%b", fl0);
  endtask

`ifdef CONDLOGIC_FLAG_SAVE_EN
  task automatic test_save_restore();
    pulse_reset();
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1010;
    tick();
    FlagW = 2'b00;
    tick();
    FlagSave = 1'b1;
    tick();
    FlagSave = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0101;
    tick();
    FlagW = 2'b00;
    tick();
    checks++; if (fl0 !== 4'b0101) begin errors++; $display("FAIL save_overwrite got=%b exp=0101", fl0); end
    FlagRestore = 1'b1;
    tick();
    FlagRestore = 1'b0;
    checks++; if (fl0 !== 4'b1010) begin errors++; $display("FAIL save_restore got=%b exp=1010", fl0); end
    idle();
    $display("test_save_restore done flags=%b", fl0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_flag_write();
    test_cond_fail();
    test_sweep();
    test_saturate();
    test_reset_pending();
    test_back_to_back();
`ifdef CONDLOGIC_FLAG_SAVE_EN
    test_save_restore();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Parametrised conditional-execution unit for the multicycle ARM core.
- Holds the NZCV flag register and evaluates all 16 condition codes.
- Gates the register, memory and PC write enables, and delays flag writes by a configurable number of cycles to the ALUWB state.
- Adds a saturating condition-fail counter for performance/debug.

Parameters:
- FLAG_GROUPS, 2, number of independently writable flag groups. Legal values 1, 2, 4. The 4 flag bits are split evenly, MSB group first.
- FLAG_DELAY, 1, cycles between the condition-qualified FlagW and the flag register write. Legal values 0..2.
- UNCOND_AS_AL, 1, Cond=4'b1111: 1 gives CondEx=1, 0 gives CondEx=0.
- CNT_W, 16, width of the condition-fail counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- FlagW  in  FLAG_GROUPS  per-group flag write request from the decoder
- PCS  in  1  instruction writes PC
- NextPC  in  1  FSM fetch-state PC increment
- RegW  in  1  FSM register write request
- MemW  in  1  FSM memory write request
- Issue  in  1  one-cycle strobe: instruction evaluated this cycle (Execute state)
- PCWrite  out  1  PC write enable
- RegWrite  out  1  qualified register write
- MemWrite  out  1  qualified memory write
- CondEx  out  1  current condition result
- Flags  out  4  architectural NZCV
- CondFailCount  out  CNT_W  saturating count of failed conditions

Behaviour:
- All state resets synchronously on the clk edge with reset=1: Flags=0, delay pipeline=0, CondFailCount=0.
- CondEx is combinational from Cond and the registered Flags (not from ALUFlags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 per UNCOND_AS_AL.
- Outputs:
  - RegWrite = RegW & CondEx
  - MemWrite = MemW & CondEx
  - PCWrite = NextPC | (PCS & CondEx)
- Flag write path:
  - FW0 = FlagW & {FLAG_GROUPS{CondEx}}.
  - FLAG_DELAY=0: FW0 drives the group enables directly.
  - FLAG_DELAY=k: FW0 passes through a k-stage shift register of flopr stages (reset 0).
  - Group g is written from the matching ALUFlags slice on the edge where its delayed enable is 1; ALUFlags is sampled at write time, not at FW0 time.
  - Groups never enabled hold their value.
- CondEx is evaluated against pre-write Flags. A flag write and a dependent condition in the same cycle see the old flags, with no bypass.
- CondFailCount:
  - Increments by 1 on each cycle with Issue=1 and CondEx=0.
  - Saturates at all-ones with no wrap.
  - Issue=0 leaves it unchanged.
- Reset mid-operation: pending delayed flag writes are discarded and the flags clear on the same edge.
- Reset overrides every enable.

Optional Feature:
- Macro: CONDLOGIC_FLAG_SAVE_EN.
- With the macro defined:
  - Adds inputs FlagSave (1) and FlagRestore (1), plus a 4-bit shadow register (reset 0).
  - FlagSave copies Flags to the shadow.
  - FlagRestore loads Flags from the shadow and takes priority over any delayed flag write in the same cycle.
  - Save and Restore in the same cycle: the restore uses the old shadow, then the shadow is updated with the pre-restore Flags.
- Without the macro: the ports and shadow are absent, and behaviour is exactly as above.

Decomposition:
- Package cond_pkg:
  - localparams for the 16 condition encodings (COND_EQ..COND_AL, COND_NV)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - legal FLAG_GROUPS values.
- One natural sub-module: cond_eval, a purely combinational Cond/Flags to CondEx evaluator with the UNCOND_AS_AL parameter.
- Reuse flopr/flopenr for the delay pipeline and flag groups.

Test Plan:
- Reset with ALUFlags=4'hF and FlagW=2'b11 held -> Flags=0, CondFailCount=0, PCWrite=NextPC only.
- Defaults, Cond=AL, FlagW=2'b10, ALUFlags=4'b0100 -> Flags=4'b0100 exactly one cycle later (FLAG_DELAY=1). Then Cond=EQ, RegW=1 -> RegWrite=1.
- Flags=4'b0100, Cond=NE, FlagW=2'b11, MemW=1, Issue=1 -> MemWrite=0, no flag update after the delay, CondFailCount=1.
- Sweep all 16 Cond values over all 16 Flags values -> CondEx matches the table. Cond=1111 gives 1 with UNCOND_AS_AL=1 and 0 with UNCOND_AS_AL=0.
- CNT_W=4, Issue=1 with a failing Cond for 20 cycles -> CondFailCount saturates at 4'hF.
- FLAG_DELAY=2, qualified FlagW issued, then reset asserted one cycle later -> Flags stay 0. With CONDLOGIC_FLAG_SAVE_EN: save 4'b1010, overwrite, restore -> Flags=4'b1010.
